// File: rtl/seven_segment_mux.sv
// Two-digit time-multiplexer for a shared seven-segment decoder and common-anode display.
// Define SEG_MUX_DEADTIME_EN to insert all-anodes-off blanking between digits.
module seven_segment_mux #(
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] digit,
    output logic [1:0] an,
    output logic       frame
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

`ifdef SEG_MUX_DEADTIME_EN
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        DIG0   = 2'd0,
        BLANK0 = 2'd1,
        DIG1   = 2'd2,
        BLANK1 = 2'd3
    } state_t;

    // Starting in the blank phase keeps the first lit digit clean after reset.
    localparam state_t RESET_STATE = BLANK1;
`else
    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } state_t;

    localparam state_t RESET_STATE = DIG0;
`endif

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic            frame_reg;
    logic            last_cycle;

    always_comb begin
        last_cycle = 1'b0;
        state_next = state_reg;
        case (state_reg)
`ifdef SEG_MUX_DEADTIME_EN
            DIG0: begin
                last_cycle = (cnt_reg == DWELL_LAST);
                state_next = BLANK0;
            end
            BLANK0: begin
                last_cycle = (cnt_reg == BLANK_LAST);
                state_next = DIG1;
            end
            DIG1: begin
                last_cycle = (cnt_reg == DWELL_LAST);
                state_next = BLANK1;
            end
            BLANK1: begin
                last_cycle = (cnt_reg == BLANK_LAST);
                state_next = DIG0;
            end
`else
            DIG0: begin
                last_cycle = (cnt_reg == DWELL_LAST);
                state_next = DIG1;
            end
            DIG1: begin
                last_cycle = (cnt_reg == DWELL_LAST);
                state_next = DIG0;
            end
`endif
            default: begin
                last_cycle = 1'b1;
                state_next = RESET_STATE;
            end
        endcase
    end

    // Every advance into DIG0 comes from another state, so the pulse marks frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RESET_STATE;
            cnt_reg   <= '0;
            frame_reg <= 1'b0;
        end else if (last_cycle) begin
            state_reg <= state_next;
            cnt_reg   <= '0;
            frame_reg <= (state_next == DIG0);
        end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            frame_reg <= 1'b0;
        end
    end

    // Digit values pass straight through so live switch changes show immediately.
    always_comb begin
        an    = 2'b11;
        digit = 4'h0;
        case (state_reg)
            DIG0: begin
                an    = 2'b10;
                digit = s0;
            end
            DIG1: begin
                an    = 2'b01;
                digit = s1;
            end
            default: begin
                an    = 2'b11;
                digit = 4'h0;
            end
        endcase
    end

    assign frame = frame_reg;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Randomized scoreboard bench for seven_segment_mux: a main instance (dwell 4, blank 2)
// and an edge-parameter instance (dwell 1, blank 1) checked against a cycle-position model.
module tb_seven_segment_mux;

    typedef struct packed {
        logic [1:0] an;
        logic [3:0] digit;
        logic       frame;
    } exp_t;

`ifdef SEG_MUX_DEADTIME_EN
    localparam int DT = 1;
`else
    localparam int DT = 0;
`endif
    localparam int MD = 4;
    localparam int MB = 2;
    localparam int MB_EFF = DT ? MB : 0;
    localparam int P_MAIN = 2 * (MD + MB_EFF);

    logic       clk;
    logic       reset_n;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] digit_m, digit_e;
    logic [1:0] an_m, an_e;
    logic       frame_m, frame_e;

    int checks = 0;
    int errors = 0;
    int t_cnt  = 0;
    exp_t q_main[$];
    exp_t q_edge[$];

    seven_segment_mux #(.DWELL_CYCLES(MD), .BLANK_CYCLES(MB)) dut_main (
        .clk(clk), .reset_n(reset_n), .s0(s0), .s1(s1),
        .digit(digit_m), .an(an_m), .frame(frame_m)
    );

    seven_segment_mux #(.DWELL_CYCLES(1), .BLANK_CYCLES(1)) dut_edge (
        .clk(clk), .reset_n(reset_n), .s0(s0), .s1(s1),
        .digit(digit_e), .an(an_e), .frame(frame_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs from the position t within the display period since reset release.
    function automatic exp_t model(input int t, input int d, input int b,
                                   input logic [3:0] v0, input logic [3:0] v1);
        exp_t e;
        int blank;
        int p;
        blank   = DT ? b : 0;
        p       = t % (2 * (d + blank));
        e.an    = 2'b11;
        e.digit = 4'h0;
        e.frame = 1'b0;
        if (p >= blank && p < blank + d) begin
            e.an    = 2'b10;
            e.digit = v0;
            e.frame = (p == blank) && (blank > 0 || t >= 2 * d);
        end else if (p >= 2 * blank + d && p < 2 * blank + 2 * d) begin
            e.an    = 2'b01;
            e.digit = v1;
        end
        return e;
    endfunction

    function automatic exp_t reset_exp(input logic [3:0] v0);
        exp_t e;
        e.frame = 1'b0;
        if (DT != 0) begin
            e.an    = 2'b11;
            e.digit = 4'h0;
        end else begin
            e.an    = 2'b10;
            e.digit = v0;
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b);
        @(posedge clk);
        #1;
        reset_n = r;
        s0      = a;
        s1      = b;
        if (!r) begin
            q_main.push_back(reset_exp(a));
            q_edge.push_back(reset_exp(a));
            t_cnt = 0;
        end else begin
            q_main.push_back(model(t_cnt, MD, MB, a, b));
            q_edge.push_back(model(t_cnt, 1, 1, a, b));
            t_cnt++;
        end
    endtask

    task automatic compare(input string name, input exp_t e, input logic [1:0] an_a,
                           input logic [3:0] dig_a, input logic fr_a);
        checks += 3;
        if (an_a !== e.an) begin
            errors++;
            $display("FAIL %s_an t=%0t got %b want %b", name, $time, an_a, e.an);
        end
        if (dig_a !== e.digit) begin
            errors++;
            $display("FAIL %s_digit t=%0t got %h want %h", name, $time, dig_a, e.digit);
        end
        if (fr_a !== e.frame) begin
            errors++;
            $display("FAIL %s_frame t=%0t got %b want %b", name, $time, fr_a, e.frame);
        end
        checks++;
        if (an_a === 2'b00) begin
            errors++;
            $display("FAIL %s_an_both_on t=%0t got %b want not 00", name, $time, an_a);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_main.size() > 0) begin
            e = q_main.pop_front();
            compare("main", e, an_m, digit_m, frame_m);
            $display("main t=%0t rst_n=%b s0=%h s1=%h an=%b digit=%h frame=%b",
                     $time, reset_n, s0, s1, an_m, digit_m, frame_m);
        end
        if (q_edge.size() > 0) begin
            e = q_edge.pop_front();
            compare("edge", e, an_e, digit_e, frame_e);
        end
    end

    initial begin
        logic [3:0] v0;
        logic       hit;
        reset_n = 1'b0;
        s0      = 4'h3;
        s1      = 4'hA;

        repeat (3) step(1'b0, 4'h3, 4'hA);

        // Release, then switch s0 to F during the second DIG0 cycle.
        v0 = 4'h3;
        for (int i = 0; i < 3 * P_MAIN; i++) begin
            if (t_cnt == MB_EFF + 1) v0 = 4'hF;
            step(1'b1, v0, 4'hA);
        end

        // Reset during the third DIG1 cycle, then replay the start-up sequence.
        hit = 1'b0;
        for (int i = 0; i < 2 * P_MAIN && !hit; i++) begin
            if ((t_cnt % P_MAIN) == 2 * MB_EFF + MD + 2) begin
                step(1'b0, 4'h3, 4'hA);
                step(1'b0, 4'h3, 4'hA);
                hit = 1'b1;
            end else begin
                step(1'b1, v0, 4'hA);
            end
        end
        for (int i = 0; i < 2 * P_MAIN; i++) step(1'b1, 4'h3, 4'hA);

        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 59) != 0);
            step(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        step(1'b1, 4'h3, 4'hA);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
